// File: rtl/fir_par_prog.sv
// L-parallel block FIR with N programmable taps and a 2-stage pipeline.
// Define FIR_PAR_SAT_EN to saturate out-of-range lanes; by default they wrap.
module fir_par_prog #(
    parameter int L     = 3,
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 32,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [L*DW-1:0]      in_data,
    input  logic                 coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic [CW-1:0]        coef_data,
    input  logic                 sync_clr,
    output logic                 out_valid,
    output logic [L*OW-1:0]      out_data,
    output logic                 out_ovf
);

    localparam int PW    = DW + CW;
    localparam int ACC_W = DW + CW + $clog2(N);
    localparam int XW    = ((ACC_W > OW) ? ACC_W : OW) + 1;
    localparam int WN    = L + N - 1;

    logic signed [CW-1:0]  h_r    [N];
    logic signed [DW-1:0]  hist_r [N-1];
    logic signed [DW-1:0]  win_s  [WN];
    logic signed [PW-1:0]  prod_r [L][N];
    logic                  v1_r;
    logic [L*OW-1:0]       sized_s;
    logic                  ovf_s;
    logic                  accept_s;

    function automatic logic out_of_range(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        hi = signed'({{(XW-1){1'b0}}, 1'b1} <<< (OW-1)) - signed'({{(XW-1){1'b0}}, 1'b1});
        lo = -signed'({{(XW-1){1'b0}}, 1'b1} <<< (OW-1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic [OW-1:0] size_lane(input logic signed [XW-1:0] v);
`ifdef FIR_PAR_SAT_EN
        if (out_of_range(v)) begin
            return v[XW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
            return v[OW-1:0];
        end
`else
        return v[OW-1:0];
`endif
    endfunction

    assign accept_s = in_valid & ~sync_clr;

    // Window index 0 is the newest sample; lane j's tap i reads index (L-1-j)+i.
    for (genvar p = 0; p < WN; p++) begin : g_win
        if (p < L) begin : g_new
            assign win_s[p] = in_data[(L-1-p)*DW +: DW];
        end else begin : g_old
            assign win_s[p] = hist_r[p-L];
        end
    end

    // Coefficient bank; reset value makes the filter a pass-through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) h_r[i] <= '0;
            h_r[0] <= {{(CW-1){1'b0}}, 1'b1};
        end else if (coef_we && (int'(coef_addr) < N)) begin
            h_r[coef_addr] <= coef_data;
        end
    end

    // Sample history: the newest N-1 samples of the window survive each accepted block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < N-1; p++) hist_r[p] <= '0;
        end else if (sync_clr) begin
            for (int p = 0; p < N-1; p++) hist_r[p] <= '0;
        end else if (in_valid) begin
            for (int p = 0; p < N-1; p++) hist_r[p] <= win_s[p];
        end
    end

    // Stage 1: all L*N products, using coefficients as they stood before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_r <= 1'b0;
            for (int j = 0; j < L; j++)
                for (int i = 0; i < N; i++) prod_r[j][i] <= '0;
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                for (int j = 0; j < L; j++)
                    for (int i = 0; i < N; i++)
                        prod_r[j][i] <= PW'(h_r[i]) * PW'(win_s[L-1-j+i]);
            end
        end
    end

    // Per-lane full-precision sum, shift, range check and output sizing.
    always_comb begin : p_sum
        logic signed [ACC_W-1:0] acc;
        logic signed [XW-1:0]    shf;
        sized_s = '0;
        ovf_s   = 1'b0;
        acc     = '0;
        shf     = '0;
        for (int j = 0; j < L; j++) begin
            acc = '0;
            for (int i = 0; i < N; i++) acc = acc + ACC_W'(prod_r[j][i]);
            shf = XW'(acc >>> SHIFT);
            sized_s[j*OW +: OW] = size_lane(shf);
            ovf_s = ovf_s | out_of_range(shf);
        end
    end

    // Stage 2: output registers; data holds between valid blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (sync_clr) begin
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= v1_r;
            out_ovf   <= v1_r & ovf_s;
            if (v1_r) out_data <= sized_s;
        end
    end

endmodule

// File: tb/tb_fir_par_prog.sv
// Directed bench for fir_par_prog: sample-history reference model plus hand-computed block checks.
module tb_fir_par_prog;
    localparam int L = 3, N = 16, DW = 16, CW = 16, OW = 16, SHIFT = 0;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [L*DW-1:0]  in_data;
    logic             coef_we;
    logic [3:0]       coef_addr;
    logic [CW-1:0]    coef_data;
    logic             sync_clr;
    logic             out_valid;
    logic [L*OW-1:0]  out_data;
    logic             out_ovf;

    always #5 clk = ~clk;

    fir_par_prog #(.L(L), .N(N), .DW(DW), .CW(CW), .OW(OW), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .sync_clr(sync_clr), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf)
    );

    typedef struct packed { logic ovf; logic [L*OW-1:0] y; } blk_t;
    typedef struct { int due; blk_t b; } exp_t;

    exp_t            q[$];
    blk_t            seen[$];
    int              xs[$];
    int              hm[N];
    logic [L*OW-1:0] last_y;
    int              pc, total, bad;
    int              hv[N] = '{11, 24, 48, 83, 130, 181, 226, 252, 252, 226, 181, 130, 83, 48, 24, 11};
    int              imp[18] = '{11, 24, 48, 83, 130, 181, 226, 252, 252, 226, 181, 130, 83, 48, 24, 11, 0, 0};

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic int lane(input blk_t b, input int j);
        logic [OW-1:0] v;
        v = b.y[j*OW +: OW];
        return int'($signed(v));
    endfunction

    task automatic chk_blk(input string nm, input int k, input int e0, input int e1, input int e2, input int eovf);
        if (k >= seen.size()) begin
            total++; bad++;
            $display("FAIL %s: got %0d blocks want at least %0d", nm, seen.size(), k + 1);
        end else begin
            chk({nm, "_l0"}, lane(seen[k], 0), e0);
            chk({nm, "_l1"}, lane(seen[k], 1), e1);
            chk({nm, "_l2"}, lane(seen[k], 2), e2);
            chk({nm, "_ovf"}, seen[k].ovf, eovf);
        end
    endtask

    task automatic model_reset();
        q.delete(); xs.delete();
        for (int i = 0; i < N; i++) hm[i] = 0;
        hm[0] = 1;
    endtask

    // y[n] = sum h[i]*x[n-i] over every sample accepted since the last clear
    task automatic accept(input int a0, input int a1, input int a2);
        exp_t   e;
        longint acc, hi, lo;
        hi = (64'sd1 <<< (OW-1)) - 64'sd1;
        lo = -(64'sd1 <<< (OW-1));
        xs.push_back(a0); xs.push_back(a1); xs.push_back(a2);
        e.due = pc + 1;
        e.b.ovf = 1'b0;
        e.b.y = '0;
        for (int j = 0; j < L; j++) begin
            int n = xs.size() - L + j;
            acc = 0;
            for (int i = 0; i < N; i++)
                if (n - i >= 0) acc += longint'(hm[i]) * longint'(xs[n-i]);
            acc = acc >>> SHIFT;
            if (acc > hi || acc < lo) begin
                e.b.ovf = 1'b1;
`ifdef FIR_PAR_SAT_EN
                acc = (acc > hi) ? hi : lo;
`endif
            end
            e.b.y[j*OW +: OW] = acc[OW-1:0];
        end
        q.push_back(e);
    endtask

    task automatic compare();
        logic ev, eovf;
        ev = (q.size() > 0) && (q[0].due == pc);
        eovf = 1'b0;
        if (ev) begin
            eovf = q[0].b.ovf;
            last_y = q[0].b.y;
            void'(q.pop_front());
        end else if (!reset) begin
            last_y = '0;
        end
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, last_y);
        chk("out_ovf", out_ovf, eovf);
        if (out_valid) seen.push_back({out_ovf, out_data});
    endtask

    task automatic tick(input logic v, input int a0, input int a1, input int a2,
                        input logic we, input int addr, input int cd, input logic clr);
        in_valid = v; in_data = {DW'(a2), DW'(a1), DW'(a0)};
        coef_we = we; coef_addr = 4'(addr); coef_data = CW'(cd); sync_clr = clr;
        @(posedge clk);
        pc++;
        if (reset) begin
            if (clr) begin
                q.delete(); xs.delete();
            end else if (v) begin
                accept(a0, a1, a2);
            end
            if (we && addr < N) hm[addr] = cd;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic blk(input int a0, input int a1, input int a2);
        tick(1'b1, a0, a1, a2, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic clr();
        tick(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic wcoef(input int addr, input int cd);
        tick(1'b0, 0, 0, 0, 1'b1, addr, cd, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; pc = 0; last_y = '0;
        reset = 1'b0;
        model_reset();
        idle(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", out_ovf, 0);
        reset = 1'b1;

        // pass-through after reset
        seen.delete();
        blk(5, -7, 9); blk(1, 2, 3); idle(3);
        chk("pt_count", seen.size(), 2);
        chk_blk("pt0", 0, 5, -7, 9, 0);
        chk_blk("pt1", 1, 1, 2, 3, 0);

        // impulse response
        for (int i = 0; i < N; i++) wcoef(i, hv[i]);
        clr();
        seen.delete();
        blk(1, 0, 0);
        for (int k = 0; k < 5; k++) blk(0, 0, 0);
        idle(3);
        chk("imp_count", seen.size(), 6);
        for (int k = 0; k < 6; k++) chk_blk("imp", k, imp[3*k], imp[3*k+1], imp[3*k+2], 0);

        // step input on alternate cycles
        clr();
        seen.delete();
        for (int k = 0; k < 7; k++) begin blk(1, 1, 1); idle(1); end
        idle(2);
        chk("step_count", seen.size(), 7);
        chk_blk("step0", 0, 11, 35, 83, 0);
        chk_blk("step5", 5, 1910, 1910, 1910, 0);
        chk_blk("step6", 6, 1910, 1910, 1910, 0);

        // overflow with OW=16
        clr();
        seen.delete();
        for (int k = 0; k < 8; k++) blk(32767, 32767, 32767);
        idle(3);
`ifdef FIR_PAR_SAT_EN
        chk_blk("ovf7", 7, 32767, 32767, 32767, 1);
`else
        chk_blk("ovf7", 7, -1910, -1910, -1910, 1);
`endif

        // reset mid-stream: in-flight block lost, coefficients back to pass-through
        clr();
        blk(2, 2, 2); idle(2);
        blk(7, 7, 7);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        model_reset();
        idle(2);
        reset = 1'b1;
        seen.delete();
        blk(4, 5, 6); idle(3);
        chk("midrst_count", seen.size(), 1);
        chk_blk("midrst_pt", 0, 4, 5, 6, 0);

        // coefficient write in the same cycle as an accepted block
        seen.delete();
        tick(1'b1, 1, 0, 0, 1'b1, 0, 2, 1'b0);
        blk(1, 0, 0); idle(3);
        chk_blk("coef_old", 0, 1, 0, 0, 0);
        chk_blk("coef_new", 1, 2, 0, 0, 0);

        // sync_clr discards the in-flight block and a same-cycle block
        wcoef(1, 1);
        clr();
        seen.delete();
        blk(3, 3, 3);
        tick(1'b1, 9, 9, 9, 1'b0, 0, 0, 1'b1);
        blk(1, 2, 3); idle(3);
        chk("clr_count", seen.size(), 1);
        chk_blk("clr_zero_hist", 0, 2, 5, 8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
